// File: rtl/multicycle_datapath.sv
// Multicycle register/memory datapath: IDLE -> READ -> EXEC -> [MEM] -> WB, one instruction at a time.
// Optional macro DATAPATH_LOGIC_OPS_EN compiles in the AND/OR opcodes; otherwise they are rejected as illegal.
module multicycle_datapath #(
  parameter int WIDTH     = 64,
  parameter int REG_COUNT = 32,
  parameter int MEM_DEPTH = 64,
  localparam int RAW      = $clog2(REG_COUNT),
  localparam int MAW      = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [RAW-1:0]   ra,
  input  logic [RAW-1:0]   rb,
  input  logic [RAW-1:0]   rw,
  input  logic [WIDTH-1:0] imm,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  input  logic [RAW-1:0]   dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [2:0] OP_LI  = 3'b000;
  localparam logic [2:0] OP_LD  = 3'b001;
  localparam logic [2:0] OP_ST  = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_BAD = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t state_reg, state_next;

  logic [2:0]       op_reg;
  logic [RAW-1:0]   ra_reg, rb_reg, rw_reg;
  logic [WIDTH-1:0] imm_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] alu_reg, alu_value;
  logic [WIDTH-1:0] mem_rdata_reg;
  logic [WIDTH-1:0] result_reg;
  logic             err_reg;
  logic [WIDTH-1:0] wb_value;

  logic op_legal, accept, is_mem_op;
  logic rf_we, mem_we;

  logic [WIDTH-1:0] rf  [REG_COUNT];
  logic [WIDTH-1:0] mem [MEM_DEPTH];
  logic [MAW-1:0]   mem_addr;

`ifdef DATAPATH_LOGIC_OPS_EN
  assign op_legal = (op != OP_BAD);
`else
  assign op_legal = (op != OP_BAD) && (op != OP_AND) && (op != OP_OR);
`endif

  assign accept    = (state_reg == S_IDLE) && start && op_legal;
  assign is_mem_op = (op_reg == OP_LD) || (op_reg == OP_ST);
  assign mem_addr  = alu_reg[MAW-1:0];

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  state_next = accept ? S_READ : S_IDLE;
      S_READ:  state_next = S_EXEC;
      S_EXEC:  state_next = is_mem_op ? S_MEM : S_WB;
      S_MEM:   state_next = S_WB;
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs and write strobes; a reset edge never commits a store
  always_comb begin
    busy   = (state_reg != S_IDLE);
    done   = (state_reg == S_WB);
    rf_we  = (state_reg == S_WB) && (op_reg != OP_ST);
    mem_we = (state_reg == S_MEM) && (op_reg == OP_ST) && reset_n;
  end

  always_comb begin
    alu_value = '0;
    case (op_reg)
      OP_LI:        alu_value = imm_reg;
      OP_LD, OP_ST: alu_value = b_reg + imm_reg;
      OP_ADD:       alu_value = a_reg + b_reg;
      OP_SUB:       alu_value = a_reg - b_reg;
`ifdef DATAPATH_LOGIC_OPS_EN
      OP_AND:       alu_value = a_reg & b_reg;
      OP_OR:        alu_value = a_reg | b_reg;
`endif
      default:      alu_value = '0;
    endcase
  end

  always_comb begin
    wb_value = alu_reg;
    case (op_reg)
      OP_LD:   wb_value = mem_rdata_reg;
      OP_ST:   wb_value = a_reg;
      default: wb_value = alu_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_reg     <= '0;
      ra_reg     <= '0;
      rb_reg     <= '0;
      rw_reg     <= '0;
      imm_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      alu_reg    <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      err_reg <= (state_reg == S_IDLE) && start && !op_legal;
      if (accept) begin
        op_reg  <= op;
        ra_reg  <= ra;
        rb_reg  <= rb;
        rw_reg  <= rw;
        imm_reg <= imm;
      end
      if (state_reg == S_READ) begin
        a_reg <= rf[ra_reg];
        b_reg <= rf[rb_reg];
      end
      if (state_reg == S_EXEC) begin
        alu_reg <= alu_value;
      end
      // result is committed together with the register write at the end of WB
      if (state_reg == S_WB) begin
        result_reg <= wb_value;
      end
    end
  end

  // Data memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= a_reg;
    end
    if (state_reg == S_MEM) begin
      mem_rdata_reg <= mem[mem_addr];
    end
  end

  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_rf
      if (gi == 0) begin : g_zero
        assign rf[gi] = '0;
      end else begin : g_reg
        logic [WIDTH-1:0] q_reg;
        always_ff @(posedge clk) begin
          if (!reset_n) begin
            q_reg <= '0;
          end else if (rf_we && (rw_reg == RAW'(gi))) begin
            q_reg <= wb_value;
          end
        end
        assign rf[gi] = q_reg;
      end
    end
  endgenerate

  assign err      = err_reg;
  assign result   = result_reg;
  assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: directed scenarios plus randomized instructions
// checked against an architectural model (register array, memory array, last-result value).
module tb_multicycle_datapath;

  localparam int W  = 64;
  localparam int NR = 32;
  localparam int MD = 64;

`ifdef DATAPATH_LOGIC_OPS_EN
  localparam bit LOGIC_EN = 1'b1;
`else
  localparam bit LOGIC_EN = 1'b0;
`endif

  localparam logic [2:0] OP_LI  = 3'd0;
  localparam logic [2:0] OP_LD  = 3'd1;
  localparam logic [2:0] OP_ST  = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_BAD = 3'd7;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [2:0]   op;
  logic [4:0]   ra, rb, rw, dbg_addr;
  logic [W-1:0] imm;
  logic         busy, done, err;
  logic [W-1:0] result, dbg_data;

  multicycle_datapath dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .ra       (ra),
    .rb       (rb),
    .rw       (rw),
    .imm      (imm),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural model
  logic [W-1:0] mregs [NR];
  logic [W-1:0] mmem  [MD];
  bit           mvalid[MD];
  int           valid_q[$];
  logic [W-1:0] exp_result;

  function automatic void model_reset();
    foreach (mregs[i]) mregs[i] = '0;
    exp_result = '0;
  endfunction

  function automatic bit model_legal(input logic [2:0] o);
    if (o == OP_BAD) return 1'b0;
    if ((o == OP_AND || o == OP_OR) && !LOGIC_EN) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_lat(input logic [2:0] o);
    if (!model_legal(o)) return 1;
    return (o == OP_LD || o == OP_ST) ? 4 : 3;
  endfunction

  // Applies one instruction to the model; returns what result should read afterwards
  function automatic logic [W-1:0] model_exec(input logic [2:0] o, input logic [4:0] a_i,
                                              input logic [4:0] b_i, input logic [4:0] w_i,
                                              input logic [W-1:0] im);
    logic [W-1:0] a, b, v;
    int addr;
    if (!model_legal(o)) return exp_result;
    a = mregs[a_i];
    b = mregs[b_i];
    addr = int'((b + im) % MD);
    v = '0;
    case (o)
      OP_LI:  v = im;
      OP_ADD: v = a + b;
      OP_SUB: v = a - b;
      OP_AND: v = a & b;
      OP_OR:  v = a | b;
      OP_LD:  v = mmem[addr];
      OP_ST: begin
        mmem[addr] = a;
        if (!mvalid[addr]) begin
          mvalid[addr] = 1'b1;
          valid_q.push_back(addr);
        end
        v = a;
      end
      default: v = '0;
    endcase
    if (o != OP_ST && w_i != 0) mregs[w_i] = v;
    exp_result = v;
    return v;
  endfunction

  // Issues one instruction with a one-cycle start pulse and reports what was observed
  task automatic issue(input logic [2:0] i_op, input logic [4:0] i_ra, input logic [4:0] i_rb,
                       input logic [4:0] i_rw, input logic [W-1:0] i_imm,
                       output int lat, output bit err_seen, output bit busy_seen,
                       output bit done_after, output bit err_after, output logic [W-1:0] res);
    @(negedge clk);
    op = i_op; ra = i_ra; rb = i_rb; rw = i_rw; imm = i_imm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    err_seen = err;
    busy_seen = busy;
    lat = 1;
    if (busy) begin
      while (!done && lat < 12) begin
        @(posedge clk); #1;
        lat++;
      end
      if (!done) lat = -1;
    end
    @(posedge clk); #1;
    done_after = done;
    err_after = err;
    res = result;
  endtask

  task automatic test_reset();
    bit all_zero;
    reset_n = 1'b0; start = 1'b0; op = '0; ra = '0; rb = '0; rw = '0; imm = '0; dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
    all_zero = 1'b1;
    for (int i = 0; i < NR; i++) begin
      dbg_addr = 5'(i); #1;
      if (dbg_data !== '0) all_zero = 1'b0;
    end
    n_cmp++; if (all_zero !== 1'b1) begin n_bad++; $display("FAIL reset_regs: got nonzero want all 0"); end
    @(negedge clk); reset_n = 1'b1;
    $display("test_reset done");
  endtask

  typedef struct packed {
    logic [2:0]   op;
    logic [4:0]   ra, rb, rw;
    logic [W-1:0] imm;
    logic [W-1:0] exp;
    logic [3:0]   lat;
  } vec_t;

  task automatic test_directed();
    vec_t tab [9];
    int lat; bit es, bs, da, ea; logic [W-1:0] res, m;
    tab = '{
      '{OP_LI,  5'd0, 5'd0, 5'd1,  64'd7,  64'd7,  4'd3},
      '{OP_LI,  5'd0, 5'd0, 5'd2,  64'd9,  64'd9,  4'd3},
      '{OP_ADD, 5'd2, 5'd1, 5'd3,  64'd0,  64'd16, 4'd3},
      '{OP_SUB, 5'd3, 5'd1, 5'd4,  64'd0,  64'd9,  4'd3},
      '{OP_SUB, 5'd0, 5'd1, 5'd5,  64'd0,  64'hFFFF_FFFF_FFFF_FFF9, 4'd3},
      '{OP_ST,  5'd3, 5'd0, 5'd0,  64'd3,  64'd16, 4'd4},
      '{OP_ST,  5'd4, 5'd0, 5'd0,  64'(MD + 4), 64'd9, 4'd4},
      '{OP_LD,  5'd0, 5'd0, 5'd31, 64'd3,  64'd16, 4'd4},
      '{OP_LD,  5'd0, 5'd0, 5'd30, 64'd4,  64'd9,  4'd4}
    };
    foreach (tab[k]) begin
      m = model_exec(tab[k].op, tab[k].ra, tab[k].rb, tab[k].rw, tab[k].imm);
      issue(tab[k].op, tab[k].ra, tab[k].rb, tab[k].rw, tab[k].imm, lat, es, bs, da, ea, res);
      $display("directed op=%0d rw=%0d imm=%0h -> lat=%0d result=%h", tab[k].op, tab[k].rw, tab[k].imm, lat, res);
      n_cmp++; if (lat !== int'(tab[k].lat)) begin n_bad++; $display("FAIL dir_latency[%0d]: got %0d want %0d", k, lat, tab[k].lat); end
      n_cmp++; if (res !== tab[k].exp) begin n_bad++; $display("FAIL dir_result[%0d]: got %h want %h", k, res, tab[k].exp); end
      n_cmp++; if (res !== m) begin n_bad++; $display("FAIL dir_model[%0d]: got %h want %h", k, res, m); end
      n_cmp++; if (da !== 1'b0) begin n_bad++; $display("FAIL dir_done_width[%0d]: got %b want 0", k, da); end
      dbg_addr = tab[k].rw; #1;
      n_cmp++; if (dbg_data !== mregs[tab[k].rw]) begin n_bad++; $display("FAIL dir_dbg[%0d]: got %h want %h", k, dbg_data, mregs[tab[k].rw]); end
    end
  endtask

  task automatic test_illegal();
    int lat; bit es, bs, da, ea; logic [W-1:0] res; bit same;
    issue(OP_BAD, 5'd1, 5'd2, 5'd1, 64'd123, lat, es, bs, da, ea, res);
    $display("illegal op=7 -> err=%b busy=%b err_next=%b", es, bs, ea);
    n_cmp++; if (es !== 1'b1) begin n_bad++; $display("FAIL illegal_err: got %b want 1", es); end
    n_cmp++; if (bs !== 1'b0) begin n_bad++; $display("FAIL illegal_busy: got %b want 0", bs); end
    n_cmp++; if (ea !== 1'b0) begin n_bad++; $display("FAIL illegal_err_width: got %b want 0", ea); end
    n_cmp++; if (res !== exp_result) begin n_bad++; $display("FAIL illegal_result: got %h want %h", res, exp_result); end
    same = 1'b1;
    for (int i = 0; i < NR; i++) begin
      dbg_addr = 5'(i); #1;
      if (dbg_data !== mregs[i]) same = 1'b0;
    end
    n_cmp++; if (same !== 1'b1) begin n_bad++; $display("FAIL illegal_regs: got changed want unchanged"); end
  endtask

  task automatic test_logic_ops();
    int lat; bit es, bs, da, ea; logic [W-1:0] res;
    logic [2:0] ops [2];
    logic [4:0] dst [2];
    ops[0] = OP_AND; dst[0] = 5'd7;
    ops[1] = OP_OR;  dst[1] = 5'd8;
    for (int k = 0; k < 2; k++) begin
      void'(model_exec(ops[k], 5'd3, 5'd4, dst[k], 64'd0));
      issue(ops[k], 5'd3, 5'd4, dst[k], 64'd0, lat, es, bs, da, ea, res);
      $display("logic op=%0d rw=%0d -> err=%b lat=%0d result=%h", ops[k], dst[k], es, lat, res);
      n_cmp++; if (es !== !model_legal(ops[k])) begin n_bad++; $display("FAIL logic_err[%0d]: got %b want %b", k, es, !model_legal(ops[k])); end
      n_cmp++; if (bs !== model_legal(ops[k])) begin n_bad++; $display("FAIL logic_busy[%0d]: got %b want %b", k, bs, model_legal(ops[k])); end
      n_cmp++; if (lat !== model_lat(ops[k])) begin n_bad++; $display("FAIL logic_lat[%0d]: got %0d want %0d", k, lat, model_lat(ops[k])); end
      n_cmp++; if (res !== exp_result) begin n_bad++; $display("FAIL logic_result[%0d]: got %h want %h", k, res, exp_result); end
      dbg_addr = dst[k]; #1;
      n_cmp++; if (dbg_data !== mregs[dst[k]]) begin n_bad++; $display("FAIL logic_dbg[%0d]: got %h want %h", k, dbg_data, mregs[dst[k]]); end
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit es, bs, da, ea; logic [W-1:0] res;
    int dones;
    void'(model_exec(OP_LI, 5'd0, 5'd0, 5'd9, 64'd5));
    issue(OP_LI, 5'd0, 5'd0, 5'd9, 64'd5, lat, es, bs, da, ea, res);
    void'(model_exec(OP_ADD, 5'd9, 5'd1, 5'd9, 64'd0));
    @(negedge clk);
    op = OP_ADD; ra = 5'd9; rb = 5'd1; rw = 5'd9; imm = '0; start = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin rw = 5'd10; ra = 5'd1; end
      if (done) begin dones++; start = 1'b0; end
    end
    start = 1'b0;
    $display("start held during ADD r9 -> done pulses=%0d result=%h", dones, result);
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL held_dones: got %0d want 1", dones); end
    n_cmp++; if (result !== exp_result) begin n_bad++; $display("FAIL held_result: got %h want %h", result, exp_result); end
    dbg_addr = 5'd9; #1;
    n_cmp++; if (dbg_data !== mregs[9]) begin n_bad++; $display("FAIL held_r9: got %h want %h", dbg_data, mregs[9]); end
    dbg_addr = 5'd10; #1;
    n_cmp++; if (dbg_data !== mregs[10]) begin n_bad++; $display("FAIL held_r10: got %h want %h", dbg_data, mregs[10]); end
  endtask

  task automatic test_reset_midway();
    int lat; bit es, bs, da, ea; logic [W-1:0] res; bit all_zero;
    // ADD r6 aborted in EXEC
    @(negedge clk);
    op = OP_ADD; ra = 5'd3; rb = 5'd1; rw = 5'd6; imm = '0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; reset_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    $display("reset in EXEC -> busy=%b done=%b err=%b result=%h", busy, done, err, result);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_done: got %b want 0", done); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL mid_result: got %h want 0", result); end
    all_zero = 1'b1;
    for (int i = 0; i < NR; i++) begin
      dbg_addr = 5'(i); #1;
      if (dbg_data !== '0) all_zero = 1'b0;
    end
    n_cmp++; if (all_zero !== 1'b1) begin n_bad++; $display("FAIL mid_regs: got nonzero want all 0"); end
    @(negedge clk); reset_n = 1'b1;
    void'(model_exec(OP_LD, 5'd0, 5'd0, 5'd1, 64'd3));
    issue(OP_LD, 5'd0, 5'd0, 5'd1, 64'd3, lat, es, bs, da, ea, res);
    $display("LD r1 mem[3] after reset -> %h", res);
    n_cmp++; if (res !== 64'd16) begin n_bad++; $display("FAIL mem_retained: got %h want 10", res); end
    // ST aborted before MEM must not touch memory
    void'(model_exec(OP_LI, 5'd0, 5'd0, 5'd2, 64'h55));
    issue(OP_LI, 5'd0, 5'd0, 5'd2, 64'h55, lat, es, bs, da, ea, res);
    @(negedge clk);
    op = OP_ST; ra = 5'd2; rb = 5'd0; rw = 5'd0; imm = 64'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; reset_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    @(negedge clk); reset_n = 1'b1;
    void'(model_exec(OP_LD, 5'd0, 5'd0, 5'd1, 64'd3));
    issue(OP_LD, 5'd0, 5'd0, 5'd1, 64'd3, lat, es, bs, da, ea, res);
    $display("LD r1 mem[3] after aborted ST -> %h", res);
    n_cmp++; if (res !== mmem[3]) begin n_bad++; $display("FAIL st_abort: got %h want %h", res, mmem[3]); end
    // reset has priority over start
    @(negedge clk);
    reset_n = 1'b0; op = OP_LI; ra = '0; rb = '0; rw = 5'd1; imm = 64'd77; start = 1'b1;
    @(posedge clk); #1;
    model_reset();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL prio_busy: got %b want 0", busy); end
    start = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;
    dbg_addr = 5'd1; #1;
    $display("reset+start same cycle -> busy=%b r1=%h", busy, dbg_data);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL prio_busy_after: got %b want 0", busy); end
    n_cmp++; if (dbg_data !== '0) begin n_bad++; $display("FAIL prio_r1: got %h want 0", dbg_data); end
  endtask

  task automatic test_random();
    int lat; bit es, bs, da, ea; logic [W-1:0] res;
    logic [2:0] o; logic [4:0] a, b, w; logic [W-1:0] im;
    bit legal; int addr; int want_lat;
    for (int n = 0; n < 150; n++) begin
      o = 3'($urandom_range(0, 7));
      a = 5'($urandom_range(0, NR - 1));
      b = 5'($urandom_range(0, NR - 1));
      w = 5'($urandom_range(0, NR - 1));
      im = {$urandom, $urandom};
      if (o == OP_LD) begin
        if (valid_q.size() == 0) begin
          o = OP_LI;
        end else begin
          addr = valid_q[$urandom_range(0, valid_q.size() - 1)];
          im = 64'(addr) - mregs[b] + ({32'($urandom), 32'($urandom)} << 6);
        end
      end
      legal = model_legal(o);
      want_lat = model_lat(o);
      void'(model_exec(o, a, b, w, im));
      issue(o, a, b, w, im, lat, es, bs, da, ea, res);
      $display("rand #%0d op=%0d ra=%0d rb=%0d rw=%0d -> err=%b lat=%0d result=%h", n, o, a, b, w, es, lat, res);
      n_cmp++; if (es !== !legal) begin n_bad++; $display("FAIL rand_err[%0d]: got %b want %b", n, es, !legal); end
      n_cmp++; if (lat !== want_lat) begin n_bad++; $display("FAIL rand_lat[%0d]: got %0d want %0d", n, lat, want_lat); end
      n_cmp++; if (res !== exp_result) begin n_bad++; $display("FAIL rand_result[%0d]: got %h want %h", n, res, exp_result); end
      dbg_addr = w; #1;
      n_cmp++; if (dbg_data !== mregs[w]) begin n_bad++; $display("FAIL rand_dbg[%0d]: got %h want %h", n, dbg_data, mregs[w]); end
    end
  endtask

  initial begin
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    model_reset();
    test_reset();
    test_directed();
    test_illegal();
    test_logic_ops();
    test_back_to_back();
    test_reset_midway();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data/register width in bits.
REQ-002 SHALL have parameter REG_COUNT, default 32, register count (power of 2); RAW = log2(REG_COUNT).
REQ-003 SHALL have parameter MEM_DEPTH, default 64, data-memory words (power of 2); MAW = log2(MEM_DEPTH).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  request to execute one instruction.
REQ-007 SHALL have port op  input  3  opcode: 000 LI, 001 LD, 010 ST, 011 ADD, 100 SUB, 101 AND, 110 OR, 111 illegal.
REQ-008 SHALL have ports ra, rb, rw  input  RAW each  source A, source B/base, destination register.
REQ-009 SHALL have port imm  input  WIDTH  immediate / address offset, two's complement.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  one-cycle pulse on rejected opcode.
REQ-013 SHALL have port result  output  WIDTH  last value written back or stored, registered.
REQ-014 SHALL have ports dbg_addr  input  RAW, dbg_data  output  WIDTH  combinational register read for test.

Function
REQ-015 FSM states SHALL be IDLE, READ, EXEC, MEM, WB; READ/EXEC/MEM/WB each last exactly one cycle.
REQ-016 In IDLE with start=1 and legal op, op/ra/rb/rw/imm SHALL be latched and FSM SHALL go to READ; inputs then ignored until IDLE.
REQ-017 start while busy=1 SHALL be ignored (no queuing).
REQ-018 READ SHALL latch A=reg[ra], B=reg[rb]; register 0 always reads 0, writes to it discarded.
REQ-019 EXEC SHALL compute: LI imm; ADD A+B; SUB A-B; AND A&B; OR A|B; LD/ST address = (B+imm) mod MEM_DEPTH (low MAW bits); arithmetic wraps modulo 2^WIDTH.
REQ-020 EXEC SHALL go to MEM for LD/ST, else to WB.
REQ-021 MEM SHALL for ST write A into mem[address]; for LD latch mem[address] (synchronous read).
REQ-022 WB SHALL write result into reg[rw] for LI/LD/ADD/SUB/AND/OR, no register write for ST; result output SHALL update in WB (ST: stored value A).
REQ-023 done SHALL be high exactly during WB; FSM SHALL return to IDLE next cycle.
REQ-024 Latency start-edge to done: 3 cycles for LI/ALU ops, 4 cycles for LD/ST; throughput one instruction per latency+1 cycles.
REQ-025 Illegal op (or disabled op, see REQ-031) in IDLE with start=1 SHALL pulse err for one cycle, stay IDLE, change no state.
REQ-026 A register read in READ SHALL see a write made by the preceding instruction's WB (no bypass needed, sequential execution).

Reset
REQ-027 reset_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, err=0, result=0, all registers to 0, in any state including mid-instruction.
REQ-028 Data memory SHALL NOT be cleared by reset; an ST aborted before MEM SHALL leave memory unchanged.
REQ-029 reset_n SHALL take priority over start in the same cycle.

Configuration
REQ-030 Macro DATAPATH_LOGIC_OPS_EN SHALL compile AND/OR support in.
REQ-031 Without DATAPATH_LOGIC_OPS_EN, opcodes 101 and 110 SHALL be treated as illegal per REQ-025; all other behaviour identical.

Verification
REQ-032 Reset then LI r1,7; LI r2,9 -> done after 3 cycles each; dbg r1=7, r2=9.
REQ-033 ADD r3,r2,r1; SUB r4,r3,r1 -> r3=16, r4=9; SUB r5,r0,r1 -> r5=2^64-7 (wrap).
REQ-034 ST r3 at imm=3 (rb=r0); ST r4 at imm=MEM_DEPTH+4; LD r31 imm=3; LD r30 imm=4 -> r31=16, r30=9 (address wrap), done 4 cycles after start.
REQ-035 op=111 with start -> err one cycle, busy stays 0, no register change; start held high during ADD -> only one instruction executed.
REQ-036 Assert reset_n=0 during EXEC of ADD r6 -> next cycle IDLE, r6=0, all dbg reads 0, memory mem[3]=16 retained.
REQ-037 With and without DATAPATH_LOGIC_OPS_EN: AND r7,r3,r4 (16&9) -> r7=0 vs err pulse; OR -> 25 vs err pulse.
